data_memory: RTL and testbench

//  Responder end of the memory-stage data port. Serves the read and write requests the

---
 rtl/y86_pkg.sv | 32 +++
 rtl/data_memory_if.sv | 37 +++
 rtl/dmem_array.sv | 41 ++++
 rtl/data_memory.sv | 170 +++++++++++++++++
 tb/tb_data_memory.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// ---------------------------------------------------------------------------
// y86_pkg
// Shared types and constants for the Y86-64 pipeline slice.
//   word_t        : 64-bit machine word
//   dmem_state_t  : data-memory responder FSM states {IDLE, WAIT, RESP}
//   stat_t/STAT_* : processor status codes; STAT_ADR is raised by the status
//                   logic when the data memory reports an address error
//   addr_in_range : word-address range check over the full 64-bit address
// ---------------------------------------------------------------------------
package y86_pkg;

    typedef logic [63:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    typedef logic [2:0] stat_t;

    localparam stat_t STAT_AOK = 3'd1;
    localparam stat_t STAT_HLT = 3'd2;
    localparam stat_t STAT_ADR = 3'd3;
    localparam stat_t STAT_INS = 3'd4;

    // Full-width compare: an address such as 2**32 + 8 must not alias word 8.
    function automatic logic addr_in_range(input word_t addr, input word_t depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/data_memory_if.sv
// ---------------------------------------------------------------------------
// data_memory_if
// Request/response channels between the memory stage (master) and the data
// memory responder (slave). Both channels use valid/ready handshakes.
//   req_valid/req_ready : request channel handshake
//   req_write           : 1 = write req_wdata, 0 = read
//   req_addr            : 64-bit word address
//   req_wdata           : write data
//   resp_valid/ready    : response channel handshake
//   resp_rdata          : read data (0 for writes and errors)
//   resp_error          : access was out of range
// ---------------------------------------------------------------------------
interface data_memory_if;
    import y86_pkg::*;

    logic  req_valid;
    logic  req_ready;
    logic  req_write;
    word_t req_addr;
    word_t req_wdata;

    logic  resp_valid;
    logic  resp_ready;
    word_t resp_rdata;
    logic  resp_error;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_error
    );

endinterface

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array
// DEPTH x 64-bit storage with one synchronous write port and one synchronous
// read port sharing a single index. The controller enables at most one port,
// and only on the commit edge of an in-range access.
//   clk   : clock, rising edge
//   we    : write enable (stores wdata at idx)
//   re    : read enable (captures mem[idx] into rdata)
//   idx   : word index
//   wdata : write data
//   rdata : registered read data, valid the cycle after re
// ---------------------------------------------------------------------------
module dmem_array
    import y86_pkg::*;
#(
    parameter  int DEPTH = 256,
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic             re,
    input  logic [IDX_W-1:0] idx,
    input  word_t            wdata,
    output word_t            rdata
);

    word_t mem [DEPTH];

    // NOTE: storage and its read register have no reset on purpose: memory
    // contents survive reset, and a reset port would prevent RAM inference.
    // The controller masks rdata outside a valid read response instead.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/data_memory.sv
// ---------------------------------------------------------------------------
// data_memory
// Responder end of the memory-stage data port. Accepts one request at a time,
// waits a fixed LATENCY, then commits the access to dmem_array and (for reads,
// and for writes when acknowledged) presents a response beat held until
// resp_ready. Addresses >= DEPTH are flagged on resp_error and on the sticky
// stat_adr flag without touching the array.
//
// Parameters:
//   DEPTH   : number of 64-bit words; req_addr is a word index
//   LATENCY : cycles from the accept edge to the commit edge (>= 1)
//
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   bus      : data_memory_if slave modport (request and response channels)
//   stat_adr : sticky address-error flag, cleared only by reset
//
// Configuration macro:
//   DMEM_WRITE_ACK_EN defined   : writes also return a response beat
//                                 (rdata = 0, resp_error valid)
//   DMEM_WRITE_ACK_EN undefined : writes commit and go straight back to IDLE
//                                 with no response beat; write errors show up
//                                 only on stat_adr
//
// Timing (accept on edge k):
//   edge k          : IDLE -> WAIT, request latched, cnt = LATENCY-1
//   edges k+1..     : cnt counts down in WAIT
//   edge k+LATENCY  : commit; WAIT -> RESP (or -> IDLE for unacknowledged write)
//   handshake edge  : RESP -> IDLE
// ---------------------------------------------------------------------------
module data_memory
    import y86_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    data_memory_if.slave  bus,
    output logic          stat_adr
);

    localparam int    IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int    CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
    localparam word_t DEPTH_W  = word_t'(DEPTH);

`ifdef DMEM_WRITE_ACK_EN
    localparam bit WRITE_ACK = 1'b1;
`else
    localparam bit WRITE_ACK = 1'b0;
`endif

    dmem_state_t      state;
    dmem_state_t      state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Request captured at accept; held until the access completes.
    logic  lat_write;
    word_t lat_addr;
    word_t lat_wdata;

    logic  resp_error_q;
    logic  accept;
    logic  commit;
    logic  addr_ok;
    logic  resp_needed;
    logic  arr_we;
    logic  arr_re;
    word_t arr_rdata;

    assign accept      = bus.req_valid && bus.req_ready;
    assign addr_ok     = addr_in_range(lat_addr, DEPTH_W);
    assign resp_needed = WRITE_ACK || !lat_write;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every output of this block is given a default first so that no
    // path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = WAIT;
                    cnt_nxt   = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    commit    = 1'b1;
                    state_nxt = resp_needed ? RESP : IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, request latch, error flags
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            lat_write    <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            resp_error_q <= 1'b0;
            stat_adr     <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                lat_write <= bus.req_write;
                lat_addr  <= bus.req_addr;
                lat_wdata <= bus.req_wdata;
            end
            if (commit) begin
                resp_error_q <= !addr_ok;
                if (!addr_ok) begin
                    stat_adr <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage: only an in-range access touches the array, on the commit edge.
    // ------------------------------------------------------------------
    assign arr_we = commit && lat_write && addr_ok;
    assign arr_re = commit && !lat_write && addr_ok;

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .re    (arr_re),
        .idx   (lat_addr[IDX_W-1:0]),
        .wdata (lat_wdata),
        .rdata (arr_rdata)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // req_ready is forced low while reset is asserted, not just by state.
    assign bus.req_ready  = rst_n && (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_error = (state == RESP) && resp_error_q;
    // Only a successful read exposes array data; writes and errors return 0.
    assign bus.resp_rdata = ((state == RESP) && !lat_write && !resp_error_q)
                            ? arr_rdata : '0;

endmodule

// File: tb/tb_data_memory.sv
// ---------------------------------------------------------------------------
// tb_data_memory
// Directed bench for data_memory: a LATENCY=2 instance driven from a vector
// table plus hand-written reset/backpressure sequences, and a LATENCY=1
// instance for back-to-back push/pop traffic. Expectations follow the
// DMEM_WRITE_ACK_EN setting of the build.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_data_memory;
    import y86_pkg::*;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;
`ifdef DMEM_WRITE_ACK_EN
    localparam bit WACK = 1'b1;
`else
    localparam bit WACK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stat_adr;
    logic stat_adr1;

    data_memory_if bus ();
    data_memory_if bus1 ();

    data_memory #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .stat_adr (stat_adr)
    );

    data_memory #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus1),
        .stat_adr (stat_adr1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input word_t act, input word_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit    write;
        word_t addr;
        word_t wdata;
        word_t exp_rdata;
        bit    exp_err;
        bit    exp_stat;
        string name;
    } vec_t;

    vec_t vecs [14];

    // One access on the LATENCY=2 instance. lat counts edges from the accept
    // edge until either a response beat or a return to IDLE is observed.
    task automatic access(input bit write, input word_t addr, input word_t wdata,
                          output bit got_resp, output word_t rdata,
                          output bit err, output int lat);
        int guard;
        got_resp = 1'b0;
        rdata    = '0;
        err      = 1'b0;
        lat      = 0;
        guard    = 0;
        bus.req_write = write;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_valid = 1'b1;
        while (bus.req_ready !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 20) begin
            check("accept_ready", bus.req_ready, 1);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        while (!(bus.resp_valid || bus.req_ready) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (bus.resp_valid) begin
            got_resp = 1'b1;
            rdata    = bus.resp_rdata;
            err      = bus.resp_error;
            bus.resp_ready = 1'b1;
            @(posedge clk); #1;
            bus.resp_ready = 1'b0;
            check("idle_after_handshake", {bus.resp_valid, bus.req_ready}, 2'b01);
        end
    endtask

    // One access on the LATENCY=1 instance with resp_ready held high;
    // low counts the cycles req_ready stays low after the accept edge.
    task automatic access1(input bit write, input word_t addr, input word_t wdata,
                           output bit saw_resp, output word_t rdata, output int low);
        int guard;
        saw_resp = 1'b0;
        rdata    = '0;
        low      = 0;
        guard    = 0;
        bus1.req_write = write;
        bus1.req_addr  = addr;
        bus1.req_wdata = wdata;
        bus1.req_valid = 1'b1;
        while (bus1.req_ready !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        bus1.req_valid = 1'b0;
        while (bus1.req_ready !== 1'b1 && low < 10) begin
            low++;
            if (bus1.resp_valid) begin
                saw_resp = 1'b1;
                rdata    = bus1.resp_rdata;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit    got;
        word_t rd;
        bit    er;
        int    lat;
        int    low;
        int    guard;

        vecs[0]  = '{1, 64'd8,   64'hDEAD_BEEF,            64'd0,                    0, 0, "wr8"};
        vecs[1]  = '{0, 64'd8,   64'd0,                    64'hDEAD_BEEF,            0, 0, "rd8"};
        vecs[2]  = '{1, 64'd5,   64'h55,                   64'd0,                    0, 0, "wr5"};
        vecs[3]  = '{1, 64'd0,   64'h0123_4567_89AB_CDEF,  64'd0,                    0, 0, "wr0"};
        vecs[4]  = '{1, 64'd255, 64'hA5A5_5A5A_F00D_CAFE,  64'd0,                    0, 0, "wr255"};
        vecs[5]  = '{0, 64'd0,   64'd0,                    64'h0123_4567_89AB_CDEF,  0, 0, "rd0"};
        vecs[6]  = '{0, 64'd255, 64'd0,                    64'hA5A5_5A5A_F00D_CAFE,  0, 0, "rd255"};
        vecs[7]  = '{0, 64'd5,   64'd0,                    64'h55,                   0, 0, "rd5"};
        vecs[8]  = '{0, 64'd300, 64'd0,                    64'd0,                    1, 1, "rd300"};
        vecs[9]  = '{0, 64'h1_0000_0008, 64'd0,            64'd0,                    1, 1, "rd_wrap"};
        vecs[10] = '{1, 64'd256, 64'h77,                   64'd0,                    1, 1, "wr256"};
        vecs[11] = '{0, 64'd8,   64'd0,                    64'hDEAD_BEEF,            0, 1, "rd8_sticky"};
        vecs[12] = '{1, 64'd3,   64'hCAFE_0003,            64'd0,                    0, 1, "wr3"};
        vecs[13] = '{0, 64'd3,   64'd0,                    64'hCAFE_0003,            0, 1, "rd3"};

        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b0;
        bus1.req_valid  = 1'b0;
        bus1.req_write  = 1'b0;
        bus1.req_addr   = '0;
        bus1.req_wdata  = '0;
        bus1.resp_ready = 1'b1;

        // Reset state while rst_n is held low.
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready",  bus.req_ready,  0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_rdata", bus.resp_rdata, 0);
        check("rst_resp_error", bus.resp_error, 0);
        check("rst_stat_adr",   stat_adr,       0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_req_ready", bus.req_ready, 1);

        // Table-driven accesses on the LATENCY=2 instance.
        for (int i = 0; i < 14; i++) begin
            access(vecs[i].write, vecs[i].addr, vecs[i].wdata, got, rd, er, lat);
            check({vecs[i].name, "_resp"},    got, (!vecs[i].write || WACK));
            check({vecs[i].name, "_latency"}, lat, LAT);
            if (!vecs[i].write || WACK) begin
                check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
                check({vecs[i].name, "_error"}, er, vecs[i].exp_err);
            end
            check({vecs[i].name, "_stat_adr"}, stat_adr, vecs[i].exp_stat);
        end

        // Backpressure: response held for 5 cycles while a request waits.
        bus.req_write = 1'b0;
        bus.req_addr  = 64'd8;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        guard = 0;
        while (bus.resp_valid !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("bp_resp_arrives", bus.resp_valid, 1);
        bus.req_write = 1'b1;
        bus.req_addr  = 64'd9;
        bus.req_wdata = 64'h1;
        bus.req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp_hold", {bus.resp_valid, bus.req_ready, bus.resp_error}, 3'b100);
            check("bp_rdata", bus.resp_rdata, 64'hDEAD_BEEF);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        check("bp_release_idle", {bus.resp_valid, bus.req_ready}, 2'b01);
        @(posedge clk); #1;
        check("bp_dropped_req_ignored", {bus.resp_valid, bus.req_ready}, 2'b01);

        // resp_ready while idle has no effect.
        bus.resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_resp_ready_ignored", {bus.resp_valid, bus.req_ready}, 2'b01);
        bus.resp_ready = 1'b0;

        // Reset in the middle of WAIT drops the pending write to addr 5.
        bus.req_write = 1'b1;
        bus.req_addr  = 64'd5;
        bus.req_wdata = 64'h99;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("midwait_busy", bus.req_ready, 0);
        rst_n = 1'b0;
        #1;
        check("midwait_rst_resp_valid", bus.resp_valid, 0);
        check("midwait_rst_stat_adr",   stat_adr,       0);
        check("midwait_rst_req_ready",  bus.req_ready,  0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        access(1'b0, 64'd5, 64'd0, got, rd, er, lat);
        check("after_rst_rd5_resp",  got, 1);
        check("after_rst_rd5_rdata", rd,  64'h55);
        check("after_rst_rd5_error", er,  0);

        // LATENCY=1 back-to-back pushq/popq.
        access1(1'b1, 64'd255, 64'h1234_5678_9ABC_DEF0, got, rd, low);
        check("l1_push_resp",      got, WACK);
        check("l1_push_ready_low", low, WACK ? 2 : 1);
        access1(1'b0, 64'd255, 64'd0, got, rd, low);
        check("l1_pop_resp",       got, 1);
        check("l1_pop_rdata",      rd,  64'h1234_5678_9ABC_DEF0);
        check("l1_pop_ready_low",  low, 2);
        access1(1'b1, 64'd254, 64'hFEED_FACE_0000_0001, got, rd, low);
        check("l1_push2_ready_low", low, WACK ? 2 : 1);
        access1(1'b0, 64'd254, 64'd0, got, rd, low);
        check("l1_pop2_rdata",     rd,  64'hFEED_FACE_0000_0001);
        access1(1'b0, 64'd255, 64'd0, got, rd, low);
        check("l1_pop3_rdata",     rd,  64'h1234_5678_9ABC_DEF0);
        check("l1_stat_adr",       stat_adr1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
